// File: rtl/srb_pkg.sv
// Shared types and constants for the self-trigger record builder.
//   state_e  : record builder control states
//   HDR_*    : record header layout (magic, word count, word indices)
//   hdr_word : selects one 16-bit header word from the latched record fields
package srb_pkg;

  typedef enum logic [2:0] {
    FILL,
    ARMED,
    POST,
    SEND_HDR,
    SEND_DATA
  } state_e;

  localparam logic [7:0]  HDR_MAGIC = 8'hA5;
  localparam int unsigned HDR_WORDS = 6;
  localparam int unsigned HDR_IDX_W = 3;

  localparam logic [HDR_IDX_W-1:0] HDR_IDX_ID  = 3'd0;
  localparam logic [HDR_IDX_W-1:0] HDR_IDX_TS3 = 3'd1;
  localparam logic [HDR_IDX_W-1:0] HDR_IDX_TS2 = 3'd2;
  localparam logic [HDR_IDX_W-1:0] HDR_IDX_TS1 = 3'd3;
  localparam logic [HDR_IDX_W-1:0] HDR_IDX_TS0 = 3'd4;
  localparam logic [HDR_IDX_W-1:0] HDR_IDX_LEN = 3'd5;

  // Header word idx: channel tag, timestamp high-to-low, record length
  function automatic logic [15:0] hdr_word(input logic [HDR_IDX_W-1:0] idx,
                                           input logic [7:0]           ch,
                                           input logic [63:0]          ts,
                                           input logic [15:0]          len);
    logic [15:0] w;
    w = 16'h0000;
    case (idx)
      HDR_IDX_ID:  w = {HDR_MAGIC, ch};
      HDR_IDX_TS3: w = ts[63:48];
      HDR_IDX_TS2: w = ts[47:32];
      HDR_IDX_TS1: w = ts[31:16];
      HDR_IDX_TS0: w = ts[15:0];
      HDR_IDX_LEN: w = len;
      default:     w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/selftrigger_record_builder_ring_buffer.sv
// Sample history RAM: simple dual-port, one write and one registered read port.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data
//   rd_en   : read strobe; rd_data updates one cycle later and holds otherwise
//   rd_addr : read address
module record_ring_buffer #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage carries no reset; rd_data holding when idle acts as a pipeline stall
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/selftrigger_record_builder.sv
// Per-channel record builder: keeps pre-trigger history in a ring buffer and,
// on an accepted trigger, emits header + sample window as a valid/ready stream.
//   clk, reset       : clock, synchronous active-high reset
//   enable           : sample-valid qualifier (buffer write + trigger evaluation)
//   timestamp        : latched on trigger acceptance
//   din, trigger_in  : filtered sample and its self-trigger bit
//   dout, dout_valid, dout_ready, dout_last : record word stream
//   busy             : high in every state except ARMED
//   dropped_count    : saturating count of triggers seen outside ARMED
module selftrigger_record_builder
  import srb_pkg::*;
#(
  parameter int unsigned CH_ID        = 0,
  parameter int unsigned PRE_SAMPLES  = 64,
  parameter int unsigned POST_SAMPLES = 192,
  parameter int unsigned BUF_AW       = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] timestamp,
  input  logic [15:0] din,
  input  logic        trigger_in,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy,
  output logic [15:0] dropped_count
);

  localparam int unsigned REC_LEN = PRE_SAMPLES + POST_SAMPLES;
  localparam int unsigned CNT_W   = BUF_AW + 1;

  localparam logic [CNT_W-1:0]     PRE_LAST  = CNT_W'(PRE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]     POST_LAST = CNT_W'(POST_SAMPLES - 1);
  localparam logic [CNT_W-1:0]     LEN_C     = CNT_W'(REC_LEN);
  localparam logic [CNT_W-1:0]     LEN_LAST  = CNT_W'(REC_LEN - 1);
  localparam logic [HDR_IDX_W-1:0] HDR_LAST  = HDR_IDX_W'(HDR_WORDS - 1);
  localparam logic [7:0]           CH_TAG    = 8'(CH_ID);
  localparam logic [15:0]          LEN_WORD  = 16'(REC_LEN);

  if ((1 << BUF_AW) < REC_LEN) begin : g_depth_check
    $error("record_builder: ring buffer too small for PRE_SAMPLES+POST_SAMPLES");
  end

  state_e               state_q, state_d;
  logic [BUF_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]     post_q, post_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [HDR_IDX_W-1:0] hdr_idx_q, hdr_idx_d;
  logic [63:0]          ts_q, ts_d;
  logic [15:0]          dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 dout_last_q, dout_last_d;
  logic                 busy_q, busy_d;
  logic [15:0]          dropped_q, dropped_d;

  logic        wr_en_c;
  logic        rd_en_c;
  logic        hs_c;
  logic        data_mv_c;
  logic        issue_c;
  logic        go_send_c;
  logic [15:0] rd_data;

  record_ring_buffer #(
    .AW (BUF_AW),
    .DW (16)
  ) u_ring (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (rd_en_c),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      post_q       <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      rd_vld_q     <= 1'b0;
      hdr_idx_q    <= '0;
      ts_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b1;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      post_q       <= post_d;
      rd_cnt_q     <= rd_cnt_d;
      out_cnt_q    <= out_cnt_d;
      rd_vld_q     <= rd_vld_d;
      hdr_idx_q    <= hdr_idx_d;
      ts_q         <= ts_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
    end
  end

  // Next-state, buffer control and output stage
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    post_d       = post_q;
    rd_cnt_d     = rd_cnt_q;
    out_cnt_d    = out_cnt_q;
    rd_vld_d     = rd_vld_q;
    hdr_idx_d    = hdr_idx_q;
    ts_d         = ts_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dropped_d    = dropped_q;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    go_send_c    = 1'b0;

    hs_c = dout_valid_q & dout_ready;

    // RAM word moves into dout when the output slot frees up; on the last
    // header handshake it moves directly so data follows headers without a gap
    data_mv_c = rd_vld_q &
                (((state_q == SEND_DATA) & (~dout_valid_q | dout_ready)) |
                 ((state_q == SEND_HDR) & hs_c & (hdr_idx_q == HDR_LAST)));

    // Prefetch: keep the RAM output stage full whenever it is free or draining
    issue_c = ((state_q == SEND_HDR) | (state_q == SEND_DATA)) &
              (rd_cnt_q < LEN_C) & (~rd_vld_q | data_mv_c);

    case (state_q)
      FILL: begin
        if (enable) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + BUF_AW'(1);
          fill_d   = fill_q + CNT_W'(1);
          if (fill_q == PRE_LAST) state_d = ARMED;
        end
      end
      ARMED: begin
        if (enable) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + BUF_AW'(1);
          if (trigger_in) begin
            ts_d      = timestamp;
            rd_ptr_d  = wr_ptr_q - BUF_AW'(PRE_SAMPLES);
            post_d    = CNT_W'(1);
            rd_cnt_d  = '0;
            rd_vld_d  = 1'b0;
            out_cnt_d = '0;
            if (POST_SAMPLES <= 1) go_send_c = 1'b1;
            else                   state_d   = POST;
          end
        end
      end
      POST: begin
        if (enable) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + BUF_AW'(1);
          post_d   = post_q + CNT_W'(1);
          if (post_q == POST_LAST) go_send_c = 1'b1;
        end
      end
      SEND_HDR: begin
        if (hs_c) begin
          if (hdr_idx_q != HDR_LAST) begin
            hdr_idx_d = hdr_idx_q + HDR_IDX_W'(1);
            dout_d    = hdr_word(hdr_idx_q + HDR_IDX_W'(1), CH_TAG, ts_q, LEN_WORD);
          end else begin
            state_d      = SEND_DATA;
            dout_valid_d = 1'b0;
          end
        end
      end
      SEND_DATA: begin
        if (hs_c) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          if (dout_last_q) begin
            state_d = FILL;
            fill_d  = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase

    // First header word is presented the cycle after capture completes
    if (go_send_c) begin
      state_d      = SEND_HDR;
      hdr_idx_d    = HDR_IDX_ID;
      dout_d       = hdr_word(HDR_IDX_ID, CH_TAG, ts_d, LEN_WORD);
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b0;
    end

    if (issue_c) begin
      rd_en_c  = 1'b1;
      rd_ptr_d = rd_ptr_q + BUF_AW'(1);
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
      rd_vld_d = 1'b1;
    end else if (data_mv_c) begin
      rd_vld_d = 1'b0;
    end

    if (data_mv_c) begin
      dout_d       = rd_data;
      dout_valid_d = 1'b1;
      dout_last_d  = (out_cnt_q == LEN_LAST);
      out_cnt_d    = out_cnt_q + CNT_W'(1);
    end

    if (enable & trigger_in & (state_q != ARMED) & (dropped_q != 16'hFFFF))
      dropped_d = dropped_q + 16'd1;

    busy_d = (state_d != ARMED);
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign dout_last     = dout_last_q;
  assign busy          = busy_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_selftrigger_record_builder.sv
// Directed bench for selftrigger_record_builder (default parameters).
module tb_selftrigger_record_builder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] timestamp = '0;
  logic [15:0] din = '0;
  logic        trigger_in = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_last;
  logic        busy;
  logic [15:0] dropped_count;

  selftrigger_record_builder dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .timestamp     (timestamp),
    .din           (din),
    .trigger_in    (trigger_in),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .busy          (busy),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t0;      // single-cycle trigger sample (-1: none)
    int          t1;      // second trigger start sample (-1: none)
    int          hold1;   // cycles the second trigger stays high
    int          tacc;    // sample whose trigger is expected to be accepted
    logic [63:0] ts;      // timestamp driven on the accepted sample
    bit          rnd;     // random dout_ready
    int          first;   // expected first sample value of the record
    int          drop;    // expected dropped_count
  } vec_t;

  vec_t tab[5];

  int checks = 0;
  int errors = 0;
  int sample_cnt = 0;
  bit rand_ready = 1'b0;

  logic [15:0] wq[$];
  bit          lq[$];
  int          stall_bad = 0;
  int          stall_seen = 0;
  logic [15:0] prev_dout;
  bit          prev_last;
  bit          stall_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Ready driver
  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Stream monitor: collects handshaken words, tracks stall stability
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        stall_seen++;
        if (!dout_valid || dout !== prev_dout || dout_last !== prev_last) stall_bad++;
      end
      stall_prev = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      if (dout_valid && dout_ready) begin
        wq.push_back(dout);
        lq.push_back(dout_last);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; enable = 1'b0; trigger_in = 1'b0; sample_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wq.delete();
    lq.delete();
  endtask

  task automatic feed(input int n, input int t0, input int t1, input int hold1,
                      input int tacc, input logic [63:0] ts);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      enable     = 1'b1;
      din        = 16'(sample_cnt);
      trigger_in = (sample_cnt == t0) ||
                   (t1 >= 0 && sample_cnt >= t1 && sample_cnt < t1 + hold1);
      timestamp  = (sample_cnt == tacc) ? ts : ~ts;
      sample_cnt++;
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
    trigger_in = 1'b0;
  endtask

  task automatic wait_record(input string nm);
    int n;
    n = 0;
    while (!(lq.size() > 0 && lq[lq.size()-1]) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic check_record(input string nm, input int first, input logic [63:0] ts);
    logic [15:0] hexp [6];
    int bad, bad_i, lbad;
    logic [15:0] bad_got, bad_exp, e;
    hexp[0] = 16'hA500;
    hexp[1] = ts[63:48];
    hexp[2] = ts[47:32];
    hexp[3] = ts[31:16];
    hexp[4] = ts[15:0];
    hexp[5] = 16'd256;
    check({nm, "_len"}, 64'(wq.size()), 64'd262);
    for (int h = 0; h < 6; h++)
      check($sformatf("%s_H%0d", nm, h), (h < wq.size()) ? 64'(wq[h]) : 64'hX, 64'(hexp[h]));
    bad = 0; bad_i = -1; bad_got = '0; bad_exp = '0;
    for (int k = 0; k < 256; k++) begin
      e = 16'(first + k);
      if (6 + k >= wq.size() || wq[6+k] !== e) begin
        if (bad == 0) begin
          bad_i = k;
          bad_exp = e;
          bad_got = (6 + k < wq.size()) ? wq[6+k] : 16'hXXXX;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_samples: %0d bad, first at %0d got %h required %h",
               nm, bad, bad_i, bad_got, bad_exp);
    end
    lbad = 0;
    for (int i = 0; i < lq.size(); i++)
      if (lq[i] != (i == 261)) lbad++;
    check({nm, "_last_bad"}, 64'(lbad), 64'd0);
  endtask

  initial begin
    tab[0] = '{100, -1, 0, 100, 64'h0123_4567_89AB_CDEF, 1'b0, 36, 0};
    tab[1] = '{ 10, 80, 1,  80, 64'h1111_2222_3333_4444, 1'b0, 16, 1};
    tab[2] = '{100, 150, 1, 100, 64'hFEDC_BA98_7654_3210, 1'b0, 36, 1};
    tab[3] = '{100, -1, 0, 100, 64'h0123_4567_89AB_CDEF, 1'b1, 36, 0};
    tab[4] = '{100, 120, 5, 100, 64'h8000_0000_0000_0001, 1'b0, 36, 5};

    // Reset values
    do_reset();
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_last", 64'(dout_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_dropped", 64'(dropped_count), 64'd0);

    // FILL to ARMED boundary
    feed(63, -1, -1, 0, -1, 64'd0);
    check("fill63_busy", 64'(busy), 64'd1);
    feed(1, -1, -1, 0, -1, 64'd0);
    check("fill64_busy", 64'(busy), 64'd0);
    check("fill64_valid", 64'(dout_valid), 64'd0);

    // Trigger during FILL only: no record
    do_reset();
    feed(50, 10, -1, 0, -1, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("fill_trig_dropped", 64'(dropped_count), 64'd1);
    check("fill_trig_words", 64'(wq.size()), 64'd0);

    // Table-driven records
    for (int v = 0; v < 5; v++) begin
      int sb0;
      string nm;
      nm = $sformatf("v%0d", v);
      do_reset();
      rand_ready = tab[v].rnd;
      sb0 = stall_bad;
      feed(300, tab[v].t0, tab[v].t1, tab[v].hold1, tab[v].tacc, tab[v].ts);
      wait_record(nm);
      rand_ready = 1'b0;
      check_record(nm, tab[v].first, tab[v].ts);
      check({nm, "_dropped"}, 64'(dropped_count), 64'(tab[v].drop));
      check({nm, "_stall_bad"}, 64'(stall_bad - sb0), 64'd0);
      check({nm, "_busy_after"}, 64'(busy), 64'd1);
    end
    check("stalls_exercised", 64'(stall_seen > 0), 64'd1);

    // Reset in the middle of SEND_DATA
    do_reset();
    feed(300, 100, -1, 0, 100, 64'h0123_4567_89AB_CDEF);
    begin
      int n;
      n = 0;
      while (wq.size() < 20 && n < 2000) begin
        @(posedge clk);
        n++;
      end
      check("mid_reached", 64'(n < 2000), 64'd1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 64'(dout_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd1);
    check("mid_rst_dropped", 64'(dropped_count), 64'd0);
    check("mid_rst_last", 64'(dout_last), 64'd0);
    reset = 1'b0;
    sample_cnt = 0;
    wq.delete();
    lq.delete();
    feed(300, 10, 80, 1, 80, 64'hAAAA_5555_0F0F_F0F0);
    wait_record("post_rst");
    check_record("post_rst", 16, 64'hAAAA_5555_0F0F_F0F0);
    check("post_rst_dropped", 64'(dropped_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule

// File: doc/selftrigger_record_builder.md
Name: selftrigger_record_builder

Overview:
Per-channel readout consumer of the self-trigger chain. Takes one filtered 16-bit sample stream and its trigger bit, keeps a pre-trigger history in a ring buffer, and on an accepted trigger captures a fixed window. It emits that window as a framed record (header, then samples) on a valid/ready stream toward the event merger. Forty instances sit downstream of the filter/trigger block, one per channel.

Parameters:
CH_ID, 0, channel number written into the header (0..39)
PRE_SAMPLES, 64, samples recorded before the trigger sample
POST_SAMPLES, 192, samples recorded from the trigger sample onward (includes the trigger sample)
BUF_AW, 9, ring buffer address width; 2**BUF_AW must be >= PRE_SAMPLES+POST_SAMPLES (elaboration check)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  sample-valid qualifier; buffer written only when 1
timestamp  in  64  free-running timestamp, sampled at trigger acceptance
din  in  16  filtered sample (signed, passed through unmodified)
trigger_in  in  1  self-trigger bit for this channel, level-sampled each enabled cycle
dout  out  16  record word
dout_valid  out  1  dout holds a valid word
dout_ready  in  1  downstream accepts word when dout_valid & dout_ready
dout_last  out  1  marks the final word of a record
busy  out  1  high in every state except ARMED
dropped_count  out  16  saturating count of rejected triggers

Behaviour:
- Reset values: dout=0, dout_valid=0, dout_last=0, busy=1, dropped_count=0; state=FILL; fill counter=0; write pointer=0.
- L = PRE_SAMPLES+POST_SAMPLES. Record = 6 header words + L sample words:
  - H0={8'hA5,CH_ID[7:0]}
  - H1..H4 = timestamp[63:48],[47:32],[31:16],[15:0]
  - H5 = L[15:0]
- FILL: writes din on each enable cycle; counts up to PRE_SAMPLES. Go to ARMED in the cycle the PRE_SAMPLES-th write occurs.
- ARMED: writes continue. trigger_in=1 & enable=1 accepts the trigger, and in that cycle:
  - latch timestamp;
  - latch start address = wr_ptr - PRE_SAMPLES (mod 2**BUF_AW), where wr_ptr is the address being written by the trigger sample;
  - post counter = 1;
  - go to POST.
  - The trigger sample is record sample index PRE_SAMPLES.
- POST: writes continue on enable cycles; post counter increments per write. When it reaches POST_SAMPLES, stop writing and go to SEND_HDR. enable=0 pauses the count.
- SEND_HDR: present H0..H5 in order, one word per handshake. First header word is valid the cycle after POST completes.
- SEND_DATA: read L words from the start address upward, wrapping modulo depth.
  - RAM read latency is 1 cycle; a registered output stage with prefetch gives no bubbles when dout_ready stays high (one word per cycle).
  - dout_last=1 only on sample L-1.
  - After the last handshake: clear the fill counter and go to FILL. History is not preserved across records.
- Stream rules: while dout_valid & !dout_ready, dout and dout_last hold stable. dout_valid never drops without a handshake.
- Writes are frozen in SEND_*, so no overwrite hazard exists.
- Dropped triggers: trigger_in=1 & enable=1 in FILL, POST, SEND_HDR or SEND_DATA increments dropped_count, saturating at 16'hFFFF. Level-sampled: a trigger held high N cycles in POST counts N.
- enable=0: no write, no trigger evaluation. The SEND_* states proceed regardless of enable.
- Reset mid-operation: any in-flight record is abandoned; all outputs take reset values the next cycle. No partial record is resumed.
- Samples are stored and emitted bit-exact with no arithmetic. Pointers wrap modulo 2**BUF_AW.

Decomposition:
- Package srb_pkg: state enum {FILL, ARMED, POST, SEND_HDR, SEND_DATA}, HDR_MAGIC=8'hA5, HDR_WORDS=6, header index constants.
- Sub-module record_ring_buffer: simple dual-port RAM, 16-bit wide, 2**BUF_AW deep, 1-cycle registered read, written with din/enable. The FSM and the output stage stay in the top.

Test Plan:
- Reset; enable=1; din=ramp (value = write count from 0); trigger_in pulsed at sample 100 -> H0=16'hA500 (CH_ID 0), H5=256, samples 36..291 in order, dout_last on 291, dropped_count=0.
- Trigger at sample 10 (still FILL) -> no record, dropped_count=1. Next trigger at sample 80 -> record with samples 16..271.
- Trigger at 100, second 1-cycle pulse at 150 (in POST) -> exactly one record (36..291), dropped_count=1.
- Same as scenario 1 with dout_ready random 50% -> identical 262-word sequence; dout stable on every stalled cycle; no lost or duplicated word.
- timestamp=64'h0123_4567_89AB_CDEF on the trigger cycle -> H1..H4 = 0123, 4567, 89AB, CDEF.
- Reset asserted mid SEND_DATA -> next cycle dout_valid=0, busy=1, dropped_count=0. Trigger 10 samples later is dropped; trigger after 64 new samples is accepted.
